// File: rtl/ring_pkg.sv
// ring_pkg
// Shared types and helpers for the ring phase tracker: FSM state encoding,
// per-sample step classification codes, and rotate helpers that work on any
// ring width up to MAX_W bits.
package ring_pkg;

   localparam int MAX_W = 64;

   typedef enum logic [1:0] {
      ST_SYNC   = 2'd0,
      ST_TRACK  = 2'd1,
      ST_LOCKED = 2'd2,
      ST_ERROR  = 2'd3
   } state_t;

   typedef enum logic [2:0] {
      CL_HOLD  = 3'd0,
      CL_AMBIG = 3'd1,
      CL_LEFT  = 3'd2,
      CL_RIGHT = 3'd3,
      CL_BAD   = 3'd4
   } step_class_t;

   // Rotate the low w bits of v left by one; bits at and above w come back 0.
   function automatic logic [MAX_W-1:0] rot_left(input logic [MAX_W-1:0] v, input int w);
      logic [MAX_W-1:0] r;
      r = '0;
      for (int i = 1; i < MAX_W; i++) begin
         if (i < w) r[i] = v[i-1];
      end
      r[0] = v[w-1];
      return r;
   endfunction

   // Rotate the low w bits of v right by one; bits at and above w come back 0.
   function automatic logic [MAX_W-1:0] rot_right(input logic [MAX_W-1:0] v, input int w);
      logic [MAX_W-1:0] r;
      r = '0;
      for (int i = 0; i < MAX_W-1; i++) begin
         if (i < w-1) r[i] = v[i+1];
      end
      r[w-1] = v[0];
      return r;
   endfunction

endpackage

// File: rtl/ring_step_classifier.sv
// ring_step_classifier
// Combinational classification of a new ring sample against the previous one.
// Ports:
//   cur   - new ring sample
//   prev  - stored previous sample
//   kind  - HOLD / AMBIG / LEFT / RIGHT / BAD
module ring_step_classifier
   import ring_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] cur,
   input  logic [WIDTH-1:0] prev,
   output step_class_t      kind
);

   logic [WIDTH-1:0] rl;
   logic [WIDTH-1:0] rr;

   assign rl = WIDTH'(rot_left(MAX_W'(prev), WIDTH));
   assign rr = WIDTH'(rot_right(MAX_W'(prev), WIDTH));

   // HOLD is tested first: uniform patterns equal both of their own rotations.
   always_comb begin
      kind = CL_BAD;
      if (cur == prev)                 kind = CL_HOLD;
      else if (cur == rl && cur == rr) kind = CL_AMBIG;
      else if (cur == rl)              kind = CL_LEFT;
      else if (cur == rr)              kind = CL_RIGHT;
   end

endmodule

// File: rtl/ring_phase_tracker.sv
// ring_phase_tracker
// Follows a one-hot/shifting ring counter from its sampled output, locks onto
// a rotation direction, counts revolutions and flags direction/pattern errors.
// Ports:
//   clk, rst    - clock, async active-high reset
//   ring_in     - ring counter sample, qualified by ring_valid
//   clr_err     - leaves ERROR back to SYNC
//   locked, dir - lock status and locked direction (1 = left)
//   rev_count   - revolutions since lock, rev_tick pulses per revolution
//   err         - sticky error, err_count saturating error event count
//
// state     | meaning
// ----------+-------------------------------------------------------
// SYNC      | waiting for first non-HOLD sample to seed prev
// TRACK     | counting consecutive same-direction steps toward lock
// LOCKED    | locked; counting steps and revolutions in dir
// ERROR     | bad or reversed step seen while locked; await clr_err
module ring_phase_tracker
   import ring_pkg::*;
#(
   parameter int WIDTH    = 8,
   parameter int LOCK_CNT = 2,
   parameter int REV_W    = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] ring_in,
   input  logic             ring_valid,
   input  logic             clr_err,
   output logic             locked,
   output logic             dir,
   output logic [REV_W-1:0] rev_count,
   output logic             rev_tick,
   output logic             err,
   output logic [7:0]       err_count
);

   localparam int RUN_W = $clog2(LOCK_CNT + 1);
   localparam int SC_W  = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   state_t           state, state_n;
   step_class_t      kind;
   logic [WIDTH-1:0] prev, prev_n;
   logic [RUN_W-1:0] run, run_n;
   logic             trk_dir, trk_dir_n;
   logic [SC_W-1:0]  step_cnt, step_cnt_n;
   logic             locked_n, dir_n, rev_tick_n, err_n;
   logic [REV_W-1:0] rev_count_n;
   logic [7:0]       err_count_n;
   logic             step;
   logic             step_left;

   ring_step_classifier #(.WIDTH(WIDTH)) u_classifier (
      .cur  (ring_in),
      .prev (prev),
      .kind (kind)
   );

   assign step      = ring_valid && (kind != CL_HOLD);
   assign step_left = (kind == CL_LEFT);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= ST_SYNC;
         prev      <= '0;
         run       <= '0;
         trk_dir   <= 1'b0;
         step_cnt  <= '0;
         locked    <= 1'b0;
         dir       <= 1'b0;
         rev_count <= '0;
         rev_tick  <= 1'b0;
         err       <= 1'b0;
         err_count <= '0;
      end else begin
         state     <= state_n;
         prev      <= prev_n;
         run       <= run_n;
         trk_dir   <= trk_dir_n;
         step_cnt  <= step_cnt_n;
         locked    <= locked_n;
         dir       <= dir_n;
         rev_count <= rev_count_n;
         rev_tick  <= rev_tick_n;
         err       <= err_n;
         err_count <= err_count_n;
      end
   end

   always_comb begin
      state_n     = state;
      prev_n      = prev;
      run_n       = run;
      trk_dir_n   = trk_dir;
      step_cnt_n  = step_cnt;
      dir_n       = dir;
      rev_count_n = rev_count;
      rev_tick_n  = 1'b0;
      err_count_n = err_count;

      // clr_err in ERROR discards a coincident sample entirely.
      if (step && !(state == ST_ERROR && clr_err)) prev_n = ring_in;

      case (state)
         ST_SYNC: begin
            if (step) begin
               state_n = ST_TRACK;
               run_n   = '0;
            end
         end
         ST_TRACK: begin
            if (step) begin
               case (kind)
                  CL_LEFT, CL_RIGHT: begin
                     // run == 0 means no direction established yet.
                     if (run != '0 && step_left == trk_dir) run_n = run + RUN_W'(1);
                     else                                   run_n = RUN_W'(1);
                     trk_dir_n = step_left;
                  end
                  CL_AMBIG: run_n = run + RUN_W'(1);
                  default:  run_n = '0;
               endcase
               if (run_n == RUN_W'(LOCK_CNT)) begin
                  state_n     = ST_LOCKED;
                  dir_n       = trk_dir_n;
                  step_cnt_n  = '0;
                  rev_count_n = '0;
                  run_n       = '0;
               end
            end
         end
         ST_LOCKED: begin
            if (step) begin
               if (kind == CL_AMBIG || (kind == CL_LEFT && dir) || (kind == CL_RIGHT && !dir)) begin
                  if (step_cnt == SC_W'(WIDTH - 1)) begin
                     step_cnt_n  = '0;
                     rev_tick_n  = 1'b1;
                     rev_count_n = rev_count + REV_W'(1);
                  end else begin
                     step_cnt_n  = step_cnt + SC_W'(1);
                  end
               end else begin
                  state_n = ST_ERROR;
                  if (err_count != 8'hFF) err_count_n = err_count + 8'd1;
               end
            end
         end
         ST_ERROR: begin
            if (clr_err) state_n = ST_SYNC;
         end
         default: state_n = ST_SYNC;
      endcase

      locked_n = (state_n == ST_LOCKED);
      err_n    = (state_n == ST_ERROR);
   end

endmodule

// File: doc/ring_phase_tracker.md
RING_PHASE_TRACKER -- requirements
Module: ring_phase_tracker

Interface
REQ-001 SHALL have parameter WIDTH, default 8: ring width in bits.
REQ-002 SHALL have parameter LOCK_CNT, default 2: consecutive same-direction steps needed to lock.
REQ-003 SHALL have parameter REV_W, default 16: revolution counter width.
REQ-004 clk  input  1  single clock; all logic on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 ring_in  input  WIDTH  sample of the ring counter's count output.
REQ-007 ring_valid  input  1  qualifies ring_in for this cycle.
REQ-008 clr_err  input  1  clears the ERROR state.
REQ-009 locked  output  1  high while in LOCKED.
REQ-010 dir  output  1  locked direction; 1 = rotate-left, 0 = rotate-right.
REQ-011 rev_count  output  REV_W  completed revolutions since lock; wraps modulo 2^REV_W.
REQ-012 rev_tick  output  1  one-cycle pulse per completed revolution.
REQ-013 err  output  1  sticky error flag.
REQ-014 err_count  output  8  error events; saturates at 255.

Function
REQ-015 Each valid sample SHALL be classified against the stored previous sample prev:
- HOLD: ring_in == prev.
- AMBIG: both rotations match (period-2 pattern).
- LEFT: matches only {prev[W-2:0], prev[W-1]}.
- RIGHT: matches only {prev[0], prev[W-1:1]}.
- BAD: none of the above.
REQ-016 HOLD SHALL cause no state, counter or output change in any state.
REQ-017 Every valid sample other than HOLD SHALL update prev, in every state.
REQ-018 The FSM SHALL have the states SYNC, TRACK, LOCKED and ERROR.
REQ-019 SYNC: first valid sample SHALL load prev and go to TRACK with run = 0.
REQ-020 TRACK, run counting:
- LEFT/RIGHT in the same direction as the last step (or the first step) SHALL increment run.
- A direction change SHALL set run = 1 with the new direction.
- AMBIG SHALL count as a step in the current direction.
- BAD SHALL set run = 0 and stay in TRACK.
REQ-021 TRACK: run reaching LOCK_CNT SHALL enter LOCKED, set dir, and clear step_cnt and rev_count.
REQ-022 LOCKED: a step in dir or AMBIG SHALL increment step_cnt, which runs 0..WIDTH-1.
REQ-023 LOCKED: the step that wraps step_cnt from WIDTH-1 to 0 SHALL pulse rev_tick and increment rev_count in the same edge.
REQ-024 LOCKED: an opposite-direction step or BAD SHALL enter ERROR, set err, increment err_count and drop locked.
REQ-025 ERROR: classification and prev updates SHALL continue, with no other effect.
REQ-026 ERROR: clr_err SHALL enter SYNC, clear err and keep err_count.
REQ-027 clr_err in SYNC, TRACK or LOCKED SHALL have no effect.
REQ-028 clr_err and ring_valid in the same ERROR cycle: clr_err SHALL win and the sample SHALL be discarded.
REQ-029 All outputs SHALL be registered; an effect appears one cycle after the sampling edge.
REQ-030 rev_count and dir SHALL hold their values outside LOCKED until the next lock.

Reset
REQ-031 rst SHALL immediately force the following, including mid-operation:
- state = SYNC;
- prev, run, step_cnt cleared;
- locked, dir, rev_count, rev_tick, err, err_count all 0.

Structure
REQ-032 FSM state encodings and the LEFT/RIGHT/HOLD/AMBIG/BAD class codes SHALL live in shared package ring_pkg, with rotate-left/right helper functions.
REQ-033 Classification SHALL be a combinational sub-module ring_step_classifier, instantiated once.

Verification
REQ-034 After reset, feed 00000011, 00000110, 00001100 -> locked=1 and dir=1 one cycle after the third sample.
REQ-035 From lock, feed 8 further left steps -> exactly one rev_tick pulse, rev_count=1; 8 more steps -> rev_count=2.
REQ-036 Locked left on 00000110, feed 00000011 -> err=1, err_count=1, locked=0, state ERROR.
REQ-037 In ERROR, assert clr_err with ring_valid and 00001100 in the same cycle -> state SYNC, err=0, err_count=1, sample ignored.
REQ-038 Repeat 00011000 for 4 valid cycles while locked -> no output change; then feed 01010101, 10101010 in TRACK -> both count as steps, locked=1.
REQ-039 Assert rst mid-LOCKED between clock edges -> all outputs 0 before the next edge.
